// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use stall, redirect flush, multi-cycle EX wait
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MC_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_memread,
    input  logic             i_ex_redirect,
    input  logic             i_mc_start,
    input  logic             i_mc_done,
    output logic             o_pc_write,
    output logic             o_ifid_en,
    output logic             o_ifid_kill_n,
    output logic             o_idex_bubble,
    output logic             o_ex_hold,
    output logic [1:0]       o_state,
    output logic             o_mc_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam int TM_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [FC_W-1:0] FLUSH_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [TM_W-1:0] TIMER_MAX    = TM_W'(MC_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_MCWAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [FC_W-1:0] flush_left_q, flush_left_d;
    logic [TM_W-1:0] mc_timer_q, mc_timer_d;
    logic            mc_timeout_q, mc_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic mc_release;

    // A load in EX whose rd feeds the ID instruction; x0 never creates a dependency
    assign load_use = i_ex_memread && (i_ex_rd != 5'd0) &&
                      ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                       (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    // The multi-cycle wait ends on a done pulse or when the timer hits its limit
    assign mc_release = i_mc_done || (mc_timer_q == TIMER_MAX);

    // State, flush countdown, MC timer, sticky timeout and performance counters
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_RUN;
            flush_left_q <= '0;
            mc_timer_q   <= '0;
            mc_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            mc_timer_q   <= mc_timer_d;
            mc_timeout_q <= mc_timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    // Next-state: redirect outranks everything in RUN/FLUSH; MCWAIT only listens to done/timer
    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        mc_timer_d   = mc_timer_q;
        mc_timeout_d = mc_timeout_q;
        case (state_q)
            ST_RUN: begin
                if (i_ex_redirect) begin
                    flush_left_d = FLUSH_RELOAD;
                    state_d      = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
                end else if (i_mc_start && !i_mc_done) begin
                    state_d    = ST_MCWAIT;
                    mc_timer_d = TM_W'(1);
                end
            end
            ST_FLUSH: begin
                if (i_ex_redirect) begin
                    flush_left_d = FLUSH_RELOAD;
                    state_d      = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
                end else begin
                    flush_left_d = flush_left_q - FC_W'(1);
                    if (flush_left_q <= FC_W'(1)) begin
                        flush_left_d = '0;
                        state_d      = ST_RUN;
                    end
                end
            end
            ST_MCWAIT: begin
                if (mc_release) begin
                    state_d    = ST_RUN;
                    mc_timer_d = '0;
                    if (!i_mc_done) begin
                        mc_timeout_d = 1'b1;
                    end
                end else begin
                    mc_timer_d = mc_timer_q + TM_W'(1);
                end
            end
            default: begin
                state_d      = ST_RUN;
                flush_left_d = '0;
                mc_timer_d   = '0;
            end
        endcase
    end

    // Mealy pipeline controls; reset forces a frozen-but-not-killing front end
    always_comb begin
        o_pc_write    = 1'b1;
        o_ifid_en     = 1'b1;
        o_ifid_kill_n = 1'b1;
        o_idex_bubble = 1'b0;
        o_ex_hold     = 1'b0;
        if (!i_reset_n) begin
            o_pc_write = 1'b0;
            o_ifid_en  = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (i_ex_redirect) begin
                        o_ifid_kill_n = 1'b0;
                        o_idex_bubble = 1'b1;
                    end else if (i_mc_start) begin
                        if (!i_mc_done) begin
                            o_pc_write = 1'b0;
                            o_ifid_en  = 1'b0;
                            o_ex_hold  = 1'b1;
                        end
                    end else if (load_use) begin
                        o_pc_write    = 1'b0;
                        o_ifid_en     = 1'b0;
                        o_idex_bubble = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    o_ifid_kill_n = 1'b0;
                    o_idex_bubble = 1'b1;
                end
                ST_MCWAIT: begin
                    if (!mc_release) begin
                        o_pc_write = 1'b0;
                        o_ifid_en  = 1'b0;
                        o_ex_hold  = 1'b1;
                    end
                end
                default: begin
                    o_pc_write = 1'b1;
                end
            endcase
        end
    end

    // Saturating stall/flush counters, both may step in the same cycle
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!o_pc_write && (stall_cnt_q != CNT_SAT)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!o_ifid_kill_n && (flush_cnt_q != CNT_SAT)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    assign o_state      = state_q;
    assign o_mc_timeout = mc_timeout_q;
    assign o_stall_cnt  = stall_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int CNT_W = 5;

    logic             i_clk;
    logic             i_reset_n;
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic             i_id_use_rs1;
    logic             i_id_use_rs2;
    logic [4:0]       i_ex_rd;
    logic             i_ex_memread;
    logic             i_ex_redirect;
    logic             i_mc_start;
    logic             i_mc_done;
    logic             o_pc_write;
    logic             o_ifid_en;
    logic             o_ifid_kill_n;
    logic             o_idex_bubble;
    logic             o_ex_hold;
    logic [1:0]       o_state;
    logic             o_mc_timeout;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    // {pc_write, ifid_en, ifid_kill_n, idex_bubble, ex_hold, state[1:0]}
    logic [6:0] outs;
    assign outs = {o_pc_write, o_ifid_en, o_ifid_kill_n, o_idex_bubble, o_ex_hold, o_state};

    localparam logic [6:0] O_RUN   = 7'b1110000;
    localparam logic [6:0] O_LU    = 7'b0011000;
    localparam logic [6:0] O_REDIR = 7'b1101000;
    localparam logic [6:0] O_FLUSH = 7'b1101001;
    localparam logic [6:0] O_MCST  = 7'b0010100;
    localparam logic [6:0] O_MCW   = 7'b0010110;
    localparam logic [6:0] O_MCREL = 7'b1110010;
    localparam logic [6:0] O_RST   = 7'b0010000;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(
        .FLUSH_CYCLES(2),
        .MC_TIMEOUT  (8),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_id_rs1     (i_id_rs1),
        .i_id_rs2     (i_id_rs2),
        .i_id_use_rs1 (i_id_use_rs1),
        .i_id_use_rs2 (i_id_use_rs2),
        .i_ex_rd      (i_ex_rd),
        .i_ex_memread (i_ex_memread),
        .i_ex_redirect(i_ex_redirect),
        .i_mc_start   (i_mc_start),
        .i_mc_done    (i_mc_done),
        .o_pc_write   (o_pc_write),
        .o_ifid_en    (o_ifid_en),
        .o_ifid_kill_n(o_ifid_kill_n),
        .o_idex_bubble(o_idex_bubble),
        .o_ex_hold    (o_ex_hold),
        .o_state      (o_state),
        .o_mc_timeout (o_mc_timeout),
        .o_stall_cnt  (o_stall_cnt),
        .o_flush_cnt  (o_flush_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic int sat_inc(input int v);
        return (v >= (1 << CNT_W) - 1) ? v : v + 1;
    endfunction

    // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later
    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_id_use_rs1 = 1'b0; i_id_use_rs2 = 1'b0;
        i_ex_rd = 5'd0; i_ex_memread = 1'b0; i_ex_redirect = 1'b0;
        i_mc_start = 1'b0; i_mc_done = 1'b0;
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        clear_inputs();
        #2;
        n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); end
        n_cmp++; if (o_stall_cnt !== 0 || o_flush_cnt !== 0) begin n_err++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", o_stall_cnt, o_flush_cnt); end
        n_cmp++; if (o_mc_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b exp=0", o_mc_timeout); end
        i_reset_n = 1'b1;
        next_cycle();
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL reset_idle got=%b exp=%b", outs, O_RUN); end
    endtask

    task automatic test_load_use();
        // lw x5 in EX, add x6,x5,x1 in ID
        i_ex_memread = 1'b1; i_ex_rd = 5'd5; i_id_rs1 = 5'd5; i_id_use_rs1 = 1'b1; i_id_rs2 = 5'd1; i_id_use_rs2 = 1'b1;
        #1;
        n_cmp++; if (outs !== O_LU) begin n_err++; $display("FAIL lu_rs1 got=%b exp=%b", outs, O_LU); end
        next_cycle(); exp_stall = sat_inc(exp_stall);
        clear_inputs();
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_clear got=%b exp=%b", outs, O_RUN); end
        n_cmp++; if (o_stall_cnt !== CNT_W'(exp_stall)) begin n_err++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", o_stall_cnt, exp_stall); end
        // load to x0 never stalls
        i_ex_memread = 1'b1; i_ex_rd = 5'd0; i_id_rs1 = 5'd0; i_id_use_rs1 = 1'b1;
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_x0 got=%b exp=%b", outs, O_RUN); end
        next_cycle();
        // rs1 matches but is not used; rs2 does not match
        i_ex_rd = 5'd9; i_id_rs1 = 5'd9; i_id_use_rs1 = 1'b0; i_id_rs2 = 5'd3; i_id_use_rs2 = 1'b1;
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_unused got=%b exp=%b", outs, O_RUN); end
        next_cycle();
        // rs2 dependency
        i_id_rs2 = 5'd9;
        #1;
        n_cmp++; if (outs !== O_LU) begin n_err++; $display("FAIL lu_rs2 got=%b exp=%b", outs, O_LU); end
        next_cycle(); exp_stall = sat_inc(exp_stall);
        // not a load
        i_ex_memread = 1'b0;
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL lu_noload got=%b exp=%b", outs, O_RUN); end
        n_cmp++; if (o_stall_cnt !== CNT_W'(exp_stall)) begin n_err++; $display("FAIL lu_stall_cnt2 got=%0d exp=%0d", o_stall_cnt, exp_stall); end
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_redirect();
        i_ex_redirect = 1'b1;
        #1;
        n_cmp++; if (outs !== O_REDIR) begin n_err++; $display("FAIL redir_c0 got=%b exp=%b", outs, O_REDIR); end
        next_cycle(); exp_flush = sat_inc(exp_flush);
        i_ex_redirect = 1'b0;
        #1;
        n_cmp++; if (outs !== O_FLUSH) begin n_err++; $display("FAIL redir_c1 got=%b exp=%b", outs, O_FLUSH); end
        next_cycle(); exp_flush = sat_inc(exp_flush);
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL redir_done got=%b exp=%b", outs, O_RUN); end
        n_cmp++; if (o_flush_cnt !== CNT_W'(exp_flush)) begin n_err++; $display("FAIL redir_flush_cnt got=%0d exp=%0d", o_flush_cnt, exp_flush); end
    endtask

    task automatic test_redirect_priority();
        // redirect with load-use pending: flush wins, load-use ignored throughout
        i_ex_redirect = 1'b1;
        i_ex_memread = 1'b1; i_ex_rd = 5'd4; i_id_rs1 = 5'd4; i_id_use_rs1 = 1'b1;
        #1;
        n_cmp++; if (outs !== O_REDIR) begin n_err++; $display("FAIL prio_c0 got=%b exp=%b", outs, O_REDIR); end
        next_cycle(); exp_flush = sat_inc(exp_flush);
        // second redirect inside FLUSH reloads the count
        #1;
        n_cmp++; if (outs !== O_FLUSH) begin n_err++; $display("FAIL prio_reload got=%b exp=%b", outs, O_FLUSH); end
        next_cycle(); exp_flush = sat_inc(exp_flush);
        i_ex_redirect = 1'b0; i_mc_start = 1'b1;
        #1;
        n_cmp++; if (outs !== O_FLUSH) begin n_err++; $display("FAIL prio_hold got=%b exp=%b", outs, O_FLUSH); end
        next_cycle(); exp_flush = sat_inc(exp_flush);
        clear_inputs();
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL prio_end got=%b exp=%b", outs, O_RUN); end
        n_cmp++; if (o_stall_cnt !== CNT_W'(exp_stall)) begin n_err++; $display("FAIL prio_stall_cnt got=%0d exp=%0d", o_stall_cnt, exp_stall); end
        n_cmp++; if (o_flush_cnt !== CNT_W'(exp_flush)) begin n_err++; $display("FAIL prio_flush_cnt got=%0d exp=%0d", o_flush_cnt, exp_flush); end
    endtask

    task automatic test_mc_done();
        i_mc_start = 1'b1;
        #1;
        n_cmp++; if (outs !== O_MCST) begin n_err++; $display("FAIL mc_start got=%b exp=%b", outs, O_MCST); end
        next_cycle(); exp_stall = sat_inc(exp_stall);
        i_mc_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            // redirect/load-use are ignored while waiting
            i_ex_redirect = (k == 2);
            i_ex_memread = (k == 3); i_ex_rd = 5'd2; i_id_rs1 = 5'd2; i_id_use_rs1 = 1'b1;
            #1;
            n_cmp++; if (outs !== O_MCW) begin n_err++; $display("FAIL mc_wait%0d got=%b exp=%b", k, outs, O_MCW); end
            next_cycle(); exp_stall = sat_inc(exp_stall);
        end
        clear_inputs();
        i_mc_done = 1'b1;
        #1;
        n_cmp++; if (outs !== O_MCREL) begin n_err++; $display("FAIL mc_release got=%b exp=%b", outs, O_MCREL); end
        next_cycle();
        i_mc_done = 1'b0;
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL mc_after got=%b exp=%b", outs, O_RUN); end
        n_cmp++; if (o_stall_cnt !== CNT_W'(exp_stall)) begin n_err++; $display("FAIL mc_stall_cnt got=%0d exp=%0d", o_stall_cnt, exp_stall); end
        n_cmp++; if (o_mc_timeout !== 1'b0) begin n_err++; $display("FAIL mc_no_timeout got=%b exp=0", o_mc_timeout); end
    endtask

    task automatic test_mc_same_cycle();
        i_mc_start = 1'b1; i_mc_done = 1'b1;
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL mc1_outs got=%b exp=%b", outs, O_RUN); end
        next_cycle();
        clear_inputs();
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL mc1_state got=%b exp=%b", outs, O_RUN); end
    endtask

    task automatic test_timeout();
        i_mc_start = 1'b1;
        #1;
        n_cmp++; if (outs !== O_MCST) begin n_err++; $display("FAIL to_start got=%b exp=%b", outs, O_MCST); end
        next_cycle(); exp_stall = sat_inc(exp_stall);
        i_mc_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            n_cmp++; if (outs !== O_MCW) begin n_err++; $display("FAIL to_wait%0d got=%b exp=%b", k, outs, O_MCW); end
            next_cycle(); exp_stall = sat_inc(exp_stall);
        end
        #1;
        n_cmp++; if (outs !== O_MCREL) begin n_err++; $display("FAIL to_release got=%b exp=%b", outs, O_MCREL); end
        next_cycle();
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL to_after got=%b exp=%b", outs, O_RUN); end
        n_cmp++; if (o_mc_timeout !== 1'b1) begin n_err++; $display("FAIL to_flag got=%b exp=1", o_mc_timeout); end
        n_cmp++; if (o_stall_cnt !== CNT_W'(exp_stall)) begin n_err++; $display("FAIL to_stall_cnt got=%0d exp=%0d", o_stall_cnt, exp_stall); end
        next_cycle(); next_cycle();
        n_cmp++; if (o_mc_timeout !== 1'b1) begin n_err++; $display("FAIL to_sticky got=%b exp=1", o_mc_timeout); end
    endtask

    task automatic test_saturate();
        // stall and flush together: FLUSH ignores load-use, so alternate load-use runs and redirects
        i_ex_memread = 1'b1; i_ex_rd = 5'd7; i_id_rs2 = 5'd7; i_id_use_rs2 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            next_cycle(); exp_stall = sat_inc(exp_stall);
        end
        #1;
        n_cmp++; if (o_stall_cnt !== CNT_W'(exp_stall)) begin n_err++; $display("FAIL sat_stall got=%0d exp=%0d", o_stall_cnt, exp_stall); end
        n_cmp++; if (o_stall_cnt !== {CNT_W{1'b1}}) begin n_err++; $display("FAIL sat_stall_max got=%0d exp=%0d", o_stall_cnt, (1 << CNT_W) - 1); end
        clear_inputs();
        i_ex_redirect = 1'b1;
        for (int k = 0; k < 30; k++) begin
            next_cycle(); exp_flush = sat_inc(exp_flush);
        end
        i_ex_redirect = 1'b0;
        next_cycle(); exp_flush = sat_inc(exp_flush);
        next_cycle();
        n_cmp++; if (o_flush_cnt !== CNT_W'(exp_flush)) begin n_err++; $display("FAIL sat_flush got=%0d exp=%0d", o_flush_cnt, exp_flush); end
        n_cmp++; if (o_stall_cnt !== {CNT_W{1'b1}}) begin n_err++; $display("FAIL sat_stall_hold got=%0d exp=%0d", o_stall_cnt, (1 << CNT_W) - 1); end
    endtask

    task automatic test_reset_mid_mcwait();
        i_mc_start = 1'b1;
        next_cycle();
        i_mc_start = 1'b0;
        next_cycle();
        #1;
        n_cmp++; if (outs !== O_MCW) begin n_err++; $display("FAIL rst_pre got=%b exp=%b", outs, O_MCW); end
        i_reset_n = 1'b0;
        #1;
        n_cmp++; if (outs !== O_RST) begin n_err++; $display("FAIL rst_outs got=%b exp=%b", outs, O_RST); end
        n_cmp++; if (o_stall_cnt !== 0 || o_flush_cnt !== 0) begin n_err++; $display("FAIL rst_cnts got=%0d/%0d exp=0/0", o_stall_cnt, o_flush_cnt); end
        n_cmp++; if (o_mc_timeout !== 1'b0) begin n_err++; $display("FAIL rst_timeout got=%b exp=0", o_mc_timeout); end
        next_cycle(); next_cycle();
        n_cmp++; if (o_stall_cnt !== 0) begin n_err++; $display("FAIL rst_no_count got=%0d exp=0", o_stall_cnt); end
        i_reset_n = 1'b1;
        next_cycle();
        #1;
        n_cmp++; if (outs !== O_RUN) begin n_err++; $display("FAIL rst_after got=%b exp=%b", outs, O_RUN); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_priority();
        test_mc_done();
        test_mc_same_cycle();
        test_timeout();
        test_saturate();
        test_reset_mid_mcwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
